spi_send: RTL
=============

Name: spi_send

Overview:
- Parallel-to-serial SPI transmit stage; sits directly upstream of spi_recv and drives its clock, enable and serial-data inputs.
- Accepts a DATA_W-bit word through a Load/Ready handshake.
- Emits one framed transfer per word: chip enable, a leading zero bit, the data MSB-first, then a trailing bit.
- Serial clock is derived from CLK by a programmable divider.

Parameters:
- DATA_W, 10, payload width in bits.
- CLK_DIV, 16, CLK cycles per serial-clock half period; must be at least 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DataOUT  in  DATA_W  word to transmit; captured when Load is accepted.
- Load  in  1  request to start a frame.
- Ready  out  1  high only in IDLE; Load is accepted only when Ready=1.
- SCLK  out  1  serial clock to the receiver; idles high.
- SerialOUT  out  1  serial data; changes only on SCLK falling edges.
- Enable  out  1  frame enable, active-high, to the receiver.
- Done  out  1  one-CLK pulse at frame end.

Behaviour:
- Reset values: Ready=1, SCLK=1, SerialOUT=0, Enable=0, Done=0. State=IDLE, divider=0, shift register=0.
- Divider: counts 0..CLK_DIV-1 while not IDLE and raises an internal tick at CLK_DIV-1. It restarts at 0 on frame start.
- SCLK toggles on every tick.
- Handshake:
  - Load=1 with Ready=1 at edge N: DataOUT is latched, Ready=0 and Enable=1 from edge N+1, SCLK=1.
  - Load while Ready=0 is ignored; no queueing.
- States:
  - IDLE: Ready=1, waits for Load.
  - SETUP: one half period with SCLK high and SerialOUT=0.
  - LEAD: SCLK falls with SerialOUT=0, then rises. The receiver samples 0.
  - SHIFT: DATA_W full periods. Each falling edge presents the next bit, MSB first; the shift register shifts left.
  - TRAIL: one full period with SerialOUT=0.
  - HOLD: one half period with SCLK high. Then Enable=0, Ready=1, Done=1 for exactly one cycle, and the block returns to IDLE.
- Frame length: Enable stays high for exactly (2*(DATA_W+2)+2)*CLK_DIV CLK cycles, i.e. 26*CLK_DIV at the default width.
- Edge counts: exactly DATA_W+2 falling and DATA_W+2 rising SCLK edges per frame.
- Back-to-back frames: Load held high in the Done cycle is accepted on that edge. The minimum Enable-low gap is 1 CLK.
- DataOUT changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The frame is dropped and Done is not pulsed.
- SerialOUT is stable for at least CLK_DIV cycles around every SCLK rising edge.

Optional Feature:
- Macro: SPI_SEND_PARITY_EN.
- Defined: the TRAIL bit carries the even parity (XOR reduction) of the latched word instead of 0. Frame length is unchanged.
- Undefined: the TRAIL bit is always 0.

Decomposition:
- Package spi_pkg holds:
  - state encoding constants: IDLE, SETUP, LEAD, SHIFT, TRAIL, HOLD;
  - default DATA_W=10;
  - frame overhead constant FRAME_EXTRA=2 (lead + trail bits), shared with spi_recv.
- One sub-module, spi_clk_div: a counter with synchronous restart that outputs the tick. It is reused later by the receiver-side master.

Test Plan:
- Reset, then idle 50 cycles -> Ready=1, SCLK=1, Enable=0, SerialOUT=0, Done=0 throughout.
- CLK_DIV=4, Load with DataOUT=10'h2A5 -> Enable high for 104 cycles. Bits sampled on SCLK rising edges are 0,1,0,1,0,1,0,0,1,0,1,0. Done pulses once, in the cycle Enable falls.
- Loop connected to spi_recv, all 1024 values 0..1023 sent back-to-back with Load held high -> every DataIN equals the sent word. The Enable gap between frames is exactly 1 cycle.
- Load pulsed repeatedly mid-frame with different DataOUT -> ignored; the serialized word is the one accepted at frame start.
- RST asserted 37 cycles into a frame -> outputs reach reset values in the same cycle with no Done. The next Load produces a complete, correct frame.
- With SPI_SEND_PARITY_EN defined: DataOUT=10'h2A5 gives trail bit 1 (five ones), and 10'h003 gives trail bit 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit/receive pair: frame state encoding,
// default payload width and the per-frame bit overhead.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LEAD  = 3'd2,
    SHIFT = 3'd3,
    TRAIL = 3'd4,
    HOLD  = 3'd5
  } spi_state_e;

  localparam int DATA_W_DEFAULT  = 10;
  localparam int CLK_DIV_DEFAULT = 16;

  // One lead bit plus one trail bit wrap every payload.
  localparam int FRAME_EXTRA = 2;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider with synchronous restart; tick_o marks the last count
// of each DIV-cycle interval while enabled.
module spi_clk_div #(
  parameter int DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("spi_clk_div: DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_send.sv
// Parallel-to-serial SPI transmitter: frames a DATA_W-bit word as lead 0,
// payload MSB-first, trail bit. Define SPI_SEND_PARITY_EN to send even parity as the trail bit.
module spi_send
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DataOUT,
  input  logic              Load,
  output logic              Ready,
  output logic              SCLK,
  output logic              SerialOUT,
  output logic              Enable,
  output logic              Done
);

  // Handshake: Load is taken on any rising CLK edge where Ready=1 (IDLE only);
  // a Load seen while Ready=0 is dropped, never queued.

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bit_q;
  logic              phase_q;
  logic              ready_q;
  logic              sclk_q;
  logic              sout_q;
  logic              enable_q;
  logic              done_q;
  logic              tick;
  logic              accept;
  logic              trail_bit;

  assign accept = (state_q == IDLE) && Load;

  spi_clk_div #(
    .DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i     (CLK),
    .rst_i     (RST),
    .en_i      (state_q != IDLE),
    .restart_i (accept),
    .tick_o    (tick)
  );

`ifdef SPI_SEND_PARITY_EN
  logic parity_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^DataOUT;
    end
  end

  assign trail_bit = parity_q;
`else
  assign trail_bit = 1'b0;
`endif

  // phase_q=0 is the low half of a full SCLK period, 1 the high half.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      ready_q  <= 1'b1;
      sclk_q   <= 1'b1;
      sout_q   <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Load) begin
            state_q  <= SETUP;
            shift_q  <= DataOUT;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            ready_q  <= 1'b0;
            enable_q <= 1'b1;
            sclk_q   <= 1'b1;
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= LEAD;
            sclk_q  <= 1'b0;
            sout_q  <= 1'b0;
          end
        end
        LEAD: begin
          if (tick) begin
            if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
              sclk_q  <= 1'b0;
              sout_q  <= shift_q[DATA_W-1];
              shift_q <= shift_q << 1;
              phase_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
            end else if (bit_q == LAST_BIT) begin
              state_q <= TRAIL;
              sclk_q  <= 1'b0;
              sout_q  <= trail_bit;
              phase_q <= 1'b0;
            end else begin
              bit_q   <= bit_q + BW'(1);
              sclk_q  <= 1'b0;
              sout_q  <= shift_q[DATA_W-1];
              shift_q <= shift_q << 1;
              phase_q <= 1'b0;
            end
          end
        end
        TRAIL: begin
          // The trail high half runs straight into HOLD with SCLK still high.
          if (tick) begin
            if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              state_q <= HOLD;
              phase_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            sout_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Ready     = ready_q;
  assign SCLK      = sclk_q;
  assign SerialOUT = sout_q;
  assign Enable    = enable_q;
  assign Done      = done_q;

endmodule
